// File: rtl/evr_dc_pkg.sv
// Shared constants for the EVR data channel: FIFO read latency and a small
// population-count helper used to size in-flight reads.
package evr_dc_pkg;

    localparam int FIFO_RD_LATENCY = 2;
    localparam int MAX_RD_LATENCY  = 4;

    function automatic logic [2:0] popcount_lat(input logic [MAX_RD_LATENCY-1:0] bits);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < MAX_RD_LATENCY; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_buf.sv
// Synchronous circular buffer with a registered head stage: the head register
// drives the stream outputs directly, older-but-not-head words wait in the tail ring.
module stream_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       head_valid_o,
    output logic [WIDTH-1:0]           head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int TAIL_DEPTH = DEPTH - 1;
    localparam int PTR_W      = (TAIL_DEPTH > 1) ? $clog2(TAIL_DEPTH) : 1;
    localparam int TCNT_W     = $clog2(TAIL_DEPTH + 1);
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  tail_mem_q [TAIL_DEPTH];
    logic [PTR_W-1:0]  tail_rd_q, tail_rd_d;
    logic [PTR_W-1:0]  tail_wr_q, tail_wr_d;
    logic [TCNT_W-1:0] tail_cnt_q, tail_cnt_d;
    logic              head_valid_q, head_valid_d;
    logic [WIDTH-1:0]  head_data_q, head_data_d;
    logic              tail_we_s;
    logic              head_free_s;
    logic              tail_empty_s;
    logic              tail_full_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(TAIL_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Next-state: refill the head from the tail first so words leave in arrival order
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        tail_rd_d    = tail_rd_q;
        tail_wr_d    = tail_wr_q;
        tail_cnt_d   = tail_cnt_q;
        tail_we_s    = 1'b0;
        head_free_s  = !head_valid_q || pop_i;
        tail_empty_s = (tail_cnt_q == TCNT_W'(0));
        tail_full_s  = (tail_cnt_q == TCNT_W'(TAIL_DEPTH));
        if (head_free_s) begin
            if (!tail_empty_s) begin
                head_valid_d = 1'b1;
                head_data_d  = tail_mem_q[tail_rd_q];
                tail_rd_d    = ptr_inc(tail_rd_q);
                if (push_i) begin
                    tail_we_s = 1'b1;
                end else begin
                    tail_cnt_d = tail_cnt_q - TCNT_W'(1);
                end
            end else if (push_i) begin
                head_valid_d = 1'b1;
                head_data_d  = push_data_i;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (push_i && !tail_full_s) begin
            tail_we_s  = 1'b1;
            tail_cnt_d = tail_cnt_q + TCNT_W'(1);
        end else begin
            tail_cnt_d = tail_cnt_q;
        end
        if (tail_we_s) begin
            tail_wr_d = ptr_inc(tail_wr_q);
        end else begin
            tail_wr_d = tail_wr_q;
        end
    end

    // Head and ring-pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            tail_rd_q    <= '0;
            tail_wr_q    <= '0;
            tail_cnt_q   <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            tail_rd_q    <= tail_rd_d;
            tail_wr_q    <= tail_wr_d;
            tail_cnt_q   <= tail_cnt_d;
        end
    end

    // Ring storage; occupancy is tracked by the counters, so contents need no reset
    always_ff @(posedge clk) begin
        if (tail_we_s) begin
            tail_mem_q[tail_wr_q] <= push_data_i;
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_data_o  = head_data_q;
    assign count_o      = CNT_W'(head_valid_q) + CNT_W'(tail_cnt_q);

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain of the EVR event FIFO: issues reads only when a buffer slot is
// reserved for every word in flight, and presents the words as a valid/ready stream.
module fifo_stream_reader
    import evr_dc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = FIFO_RD_LATENCY
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fifo_empty,
    input  logic [WIDTH-1:0]                fifo_dout,
    output logic                            fifo_rd_en,
    output logic                            m_valid,
    output logic [WIDTH-1:0]                m_data,
    input  logic                            m_ready,
    output logic [$clog2(RD_LATENCY+3)-1:0] level
);
    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    logic [RD_LATENCY-1:0]     inflight_q, inflight_d;
    logic [RD_LATENCY:0]       shift_s;
    logic [MAX_RD_LATENCY-1:0] inflight_ext_s;
    logic [CNT_W-1:0]          inflight_cnt_s;
    logic [CNT_W-1:0]          occupancy_s;
    logic [CNT_W-1:0]          count_s;
    logic                      land_s;
    logic                      pop_s;
    logic                      rd_en_s;

    // Issue decision: occupancy counts landed words plus reads still in the FIFO pipeline
    always_comb begin
        inflight_ext_s = MAX_RD_LATENCY'(inflight_q);
        inflight_cnt_s = CNT_W'(popcount_lat(inflight_ext_s));
        occupancy_s    = count_s + inflight_cnt_s;
        rd_en_s        = !rst && !fifo_empty && (occupancy_s < CNT_W'(BUF_DEPTH));
        shift_s        = {inflight_q, rd_en_s};
        inflight_d     = shift_s[RD_LATENCY-1:0];
    end

    // In-flight tracker: a bit reaching the top marks fifo_dout as valid this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign land_s = inflight_q[RD_LATENCY-1];
    assign pop_s  = m_valid && m_ready;

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (land_s),
        .push_data_i  (fifo_dout),
        .pop_i        (pop_s),
        .head_valid_o (m_valid),
        .head_data_o  (m_data),
        .count_o      (count_s)
    );

    assign fifo_rd_en = rd_en_s;
    assign level      = count_s;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO source model with fixed read latency,
// word-count/ordering model checked every cycle, plus directed literal checks.
module tb_fifo_stream_reader;
    localparam int WIDTH  = 32;
    localparam int LAT    = 2;
    localparam int BDEPTH = LAT + 2;
    localparam int SRC_N  = 4096;
    localparam int CUM_N  = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [2:0]       level;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .RD_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .level      (level)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // FIFO source: words written by the stimulus, drained by fifo_rd_en
    logic [WIDTH-1:0] src_mem [SRC_N];
    int               src_wr = 0;
    int               src_rd = 0;
    logic             gate_empty = 1'b0;
    logic [WIDTH-1:0] pipe [LAT];
    assign fifo_empty = gate_empty || (src_rd == src_wr);
    assign fifo_dout  = pipe[LAT-1];

    // Model state: cumulative reads per cycle, accepted words, words owed in order
    int               cyc = 0;
    int               rd_cum [CUM_N];
    int               acc_cum = 0;
    int               rd_total = 0;
    int               acc_total = 0;
    logic             mdl_ok = 1'b0;
    logic [WIDTH-1:0] exp_q [$];

    function automatic int cum(input int c);
        return (c <= 0) ? 0 : rd_cum[c];
    endfunction
    function automatic int exp_infl();
        return cum(cyc) - cum(cyc - LAT);
    endfunction
    function automatic int exp_level();
        return cum(cyc - LAT) - acc_cum;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            src_rd  <= src_wr;
            cyc     <= 0;
            rd_cum[0] <= 0;
            acc_cum <= 0;
            exp_q.delete();
            mdl_ok  <= 1'b1;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (fifo_rd_en && !fifo_empty) begin
                pipe[0]  <= src_mem[src_rd % SRC_N];
                exp_q.push_back(src_mem[src_rd % SRC_N]);
                src_rd   <= src_rd + 1;
            end else begin
                pipe[0]  <= 32'hBAD0_0000 | WIDTH'(cyc);
            end
            if (fifo_rd_en) rd_total <= rd_total + 1;
            if (cyc + 1 < CUM_N) rd_cum[cyc+1] <= rd_cum[cyc] + (fifo_rd_en ? 1 : 0);
            cyc <= cyc + 1;
            if (m_valid && m_ready) begin
                acc_cum   <= acc_cum + 1;
                acc_total <= acc_total + 1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] data_prev = '0;
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("no_empty_read", fifo_rd_en && fifo_empty, 1'b0);
            chk("rd_en", fifo_rd_en, !rst && !fifo_empty && (exp_level() + exp_infl() < BDEPTH));
            chk("level", level, exp_level());
            chk("m_valid", m_valid, exp_level() != 0);
            if (m_valid && exp_q.size() > 0) chk("m_data_order", m_data, exp_q[0]);
            if (stall_prev) chk("hold_stable", {m_valid, m_data}, {1'b1, data_prev});
            stall_prev <= m_valid && !m_ready && !rst;
            data_prev  <= m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        src_mem[src_wr % SRC_N] = w;
        src_wr = src_wr + 1;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_total < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_delivery", acc_total >= target, 1'b1);
    endtask

    int r0, a0, first_rd, last_rd, first_v, vcount;

    initial begin
        rst = 1'b1;
        m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", m_valid, 1'b0);
        chk("reset_level", level, 3'd0);
        chk("reset_rd_en", fifo_rd_en, 1'b0);

        // Single word: valid three cycles after empty falls
        tick();
        m_ready = 1'b1;
        r0 = rd_total;
        load(32'hDEADBEEF);
        @(negedge clk);
        chk("single_rd_first", fifo_rd_en, 1'b1);
        chk("single_c0_valid", m_valid, 1'b0);
        @(negedge clk);
        chk("single_c1_valid", m_valid, 1'b0);
        @(negedge clk);
        chk("single_c2_valid", m_valid, 1'b0);
        @(negedge clk);
        chk("single_c3_valid", m_valid, 1'b1);
        chk("single_c3_data", m_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("single_c4_valid", m_valid, 1'b0);
        chk("single_reads", rd_total - r0, 1);

        // Streaming: 16 words, no bubbles
        tick();
        r0 = rd_total;
        for (int i = 0; i < 16; i++) load(WIDTH'(i));
        first_rd = -1; last_rd = -1; first_v = -1; vcount = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = k;
                last_rd = k;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                chk("stream_data", m_data, WIDTH'(k - 3));
                vcount++;
            end
        end
        chk("stream_first_rd", first_rd, 0);
        chk("stream_last_rd", last_rd, 15);
        chk("stream_reads", rd_total - r0, 16);
        chk("stream_first_valid", first_v, 3);
        chk("stream_valid_cycles", vcount, 16);

        // Backpressure: reads stop at buffer depth, nothing lost afterwards
        tick();
        m_ready = 1'b0;
        r0 = rd_total;
        a0 = acc_total;
        for (int i = 0; i < 16; i++) load(32'h100 + WIDTH'(i));
        repeat (10) @(negedge clk);
        chk("bp_reads", rd_total - r0, 4);
        chk("bp_level", level, 3'd4);
        chk("bp_head", {m_valid, m_data}, {1'b1, 32'h100});
        tick();
        m_ready = 1'b1;
        wait_acc(a0 + 16, 60);
        chk("bp_delivered", acc_total - a0, 16);
        chk("bp_reads_total", rd_total - r0, 16);

        // Empty flag toggling every cycle
        a0 = acc_total;
        for (int i = 0; i < 20; i++) load(32'hA000 + WIDTH'(i));
        for (int k = 0; k < 40; k++) begin
            tick();
            gate_empty = ~gate_empty;
        end
        gate_empty = 1'b0;
        wait_acc(a0 + 20, 60);
        chk("toggle_delivered", acc_total - a0, 20);

        // Reset with two reads in flight
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(32'hC000 + WIDTH'(i));
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_rd_en", fifo_rd_en, 1'b0);
        tick();
        @(negedge clk);
        chk("rst_next_valid", m_valid, 1'b0);
        chk("rst_next_level", level, 3'd0);
        chk("rst_next_rd_en", fifo_rd_en, 1'b0);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        a0 = acc_total;
        r0 = rd_total;
        repeat (6) @(negedge clk);
        chk("post_rst_no_output", acc_total - a0, 0);
        chk("post_rst_no_reads", rd_total - r0, 0);
        chk("post_rst_valid", m_valid, 1'b0);

        // Random backpressure over 1000 words
        tick();
        a0 = acc_total;
        for (int i = 0; i < 1000; i++) load($urandom);
        for (int k = 0; k < 6000 && acc_total < a0 + 1000; k++) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        wait_acc(a0 + 1000, 20);
        chk("rand_delivered", acc_total - a0, 1000);
        repeat (2) @(negedge clk);
        chk("rand_owed_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion to the dual-clock event FIFO in the EVR data channel. Lives entirely in the FIFO read clock domain, drives the FIFO's `rd_en`, tracks its fixed read latency (standard mode, output register enabled), and presents drained words as a valid/ready stream to downstream EVR logic. It is the only agent that reads the FIFO. It guarantees no underflow reads, no lost words under backpressure, and one word per cycle sustained throughput.

## Interface
Parameters:
- `WIDTH`, 32: data word width; must equal the FIFO wrapper `WIDTH`.
- `RD_LATENCY`, 2: cycles from `rd_en` sampled high to the valid word on `fifo_dout`; allowed range 1..4.

Ports:
- `clk`  in  1: FIFO read clock, same net as the FIFO `rd_clk`.
- `rst`  in  1: synchronous, active-high reset.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_dout`  in  WIDTH: FIFO data output.
- `fifo_rd_en`  out  1: FIFO read enable.
- `m_valid`  out  1: output word valid.
- `m_data`  out  WIDTH: output word.
- `m_ready`  in  1: downstream accepts the word.
- `level`  out  $clog2(RD_LATENCY+3): words held in the local buffer.

## Operation
- Local buffer depth is `BUF_DEPTH = RD_LATENCY + 2`.
  - A read is issued only when a slot is guaranteed for it.
  - No combinational path runs from `m_ready` to `fifo_rd_en`.
- In-flight tracking: a shift register `inflight[RD_LATENCY-1:0]` records one bit per issued read.
  - The bit is set when `fifo_rd_en` is high.
  - When the bit reaches the end of the register, `fifo_dout` is written into the buffer in that cycle.
- Issue rule, combinational from registered state: `fifo_rd_en = !rst && !fifo_empty && (level + popcount(inflight) < BUF_DEPTH)`.
- Pop: when `m_valid && m_ready`, the buffer head is retired.
  - Push and pop in the same cycle leave `level` unchanged.
- Outputs `m_valid` and `m_data` come straight from the buffer head register. They are not a bypass from `fifo_dout`.
- Stream rule: once `m_valid` is high, `m_valid` and `m_data` stay stable until accepted.
- Reset (`rst` high at a clock edge):
  - `inflight` is cleared, the buffer is emptied and `level` = 0.
  - `m_valid` = 0, `m_data` = 0, and `fifo_rd_en` is forced to 0 during reset.
  - Words in flight at reset are discarded. The FIFO is reset by the same `rst`, so no stale words remain.
- Width rule: `level` plus in-flight count is at most `BUF_DEPTH`, and the comparison is done at `$clog2(BUF_DEPTH+1)` bits.

## Timing
- Read path:
  - `fifo_rd_en` high in cycle n → word on `fifo_dout` in cycle n+`RD_LATENCY` → written to the buffer at the end of that cycle → `m_valid` high in cycle n+`RD_LATENCY`+1.
  - First-word latency from `fifo_empty` falling is `RD_LATENCY`+1 cycles. With `RD_LATENCY`=2 this is 3 cycles.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` stays high every cycle and `m_valid` stays high every cycle after the first word.
- Backpressure:
  - With `m_ready` = 0, reads stop once `level` plus in-flight reaches `BUF_DEPTH`.
  - All in-flight words still land, and `level` settles at `BUF_DEPTH`.
- Empty boundary: when `fifo_empty` = 1, `fifo_rd_en` = 0 in the same cycle. The block never reads an empty FIFO.
- When the buffer drains with no new reads, `m_valid` falls in the cycle after the last pop.

## Structure
- Shared package `evr_dc_pkg` holds the constant `FIFO_RD_LATENCY = 2`, which corresponds to the FIFO36 output register enabled. Both the FIFO wrapper users and this block import it.
- One natural sub-module is `stream_buf`:
  - a synchronous circular buffer with parameters `WIDTH` and `DEPTH`;
  - push/pop interface, head-registered output and a `count` output.
- The top level holds the in-flight shift register and the issue logic.

## Test plan
- Single word: FIFO holds `32'hDEADBEEF`, `m_ready` = 1 → one `fifo_rd_en` pulse; `m_valid` high 3 cycles after `fifo_empty` falls, with `m_data` = `32'hDEADBEEF`.
- Streaming: 16 words 0..15 preloaded, `m_ready` = 1 → 16 consecutive `fifo_rd_en` cycles; `m_data` shows 0..15 on consecutive cycles with no bubbles.
- Backpressure: 16 words, `m_ready` = 0 → exactly 4 reads issued and `level` = 4. Then `m_ready` = 1 → all 16 words delivered in order with none lost or duplicated.
- Random `m_ready` (50%) over 1000 words → output sequence equals input sequence, and `m_data` is stable while `m_valid && !m_ready`.
- Reset mid-stream: `rst` asserted with 2 reads in flight → next cycle `m_valid` = 0, `level` = 0 and `fifo_rd_en` = 0. After release with FIFO empty, no output.
- Empty boundary: `fifo_empty` toggles every cycle → `fifo_rd_en` is never high while `fifo_empty` = 1.
